// File: rtl/reg_pkg.sv
// Shared widths and controller state encoding for the register-file host.
package reg_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StIdle = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/reg_file_host.sv
// Host-side controller for an external register file: clears every nonzero
// address after reset, then serves single writes and dual-port reads.
module reg_file_host
  import reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = reg_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = reg_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr2,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata1,
  output logic [DATA_WIDTH-1:0] rsp_rdata2,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic                  rf_wen,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic [DATA_WIDTH-1:0] r_rdata2;
  logic                  w_accept;
  logic                  w_read_accept;

  assign cmd_ready     = (r_state == StIdle);
  assign w_accept      = cmd_valid & cmd_ready;
  assign w_read_accept = w_accept & ~cmd_write;

  assign rf_raddr1  = cmd_addr;
  assign rf_raddr2  = cmd_addr2;
  assign rsp_valid  = (r_state == StResp);
  assign init_done  = (r_state != StInit);
  assign rsp_rdata1 = r_rdata1;
  assign rsp_rdata2 = r_rdata2;

  always_comb begin
    w_state_next = r_state;
    rf_wen       = 1'b0;
    rf_waddr     = cmd_addr;
    rf_wdata     = cmd_wdata;
    unique case (r_state)
      StInit: begin
        // Reset parks the FSM here, so gate the clear write with rst itself.
        rf_wen   = rst;
        rf_waddr = r_clr_cnt;
        rf_wdata = '0;
        if (r_clr_cnt == LastAddr) begin
          w_state_next = StIdle;
        end
      end
      StIdle: begin
        if (w_accept) begin
          if (cmd_write) begin
            rf_wen = (cmd_addr != '0);
          end else begin
            w_state_next = StResp;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counter saturates at the last address so it never revisits address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_cnt <= ADDR_WIDTH'(1);
    end else if ((r_state == StInit) && (r_clr_cnt != LastAddr)) begin
      r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
    end
  end

  // Address 0 reads as zero regardless of what the register file holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else if (w_read_accept) begin
      r_rdata1 <= (cmd_addr == '0) ? '0 : rf_rdata1;
      r_rdata2 <= (cmd_addr2 == '0) ? '0 : rf_rdata2;
    end
  end

endmodule

// File: tb/tb_reg_file_host.sv
// Self-checking bench for reg_file_host with a behavioural register file alongside it.
module tb_reg_file_host;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NREG = 32;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_addr2;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata1;
  logic [DW-1:0] rsp_rdata2;
  logic          init_done;
  logic [AW-1:0] rf_waddr;
  logic          rf_wen;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rf_raddr1;
  logic [AW-1:0] rf_raddr2;
  logic [DW-1:0] rf_rdata1;
  logic [DW-1:0] rf_rdata2;

  reg_file_host #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_addr2 (cmd_addr2),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata1(rsp_rdata1),
    .rsp_rdata2(rsp_rdata2),
    .init_done (init_done),
    .rf_waddr  (rf_waddr),
    .rf_wen    (rf_wen),
    .rf_wdata  (rf_wdata),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2)
  );

  // The register file the controller drives: one write port, two async reads.
  logic [DW-1:0] rf_mem [NREG];
  always_ff @(posedge clk) begin
    if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference contents as the host should observe them.
  logic [DW-1:0] model [NREG];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    bit [AW-1:0] a1;
    bit [AW-1:0] a2;
    bit [DW-1:0] wd;
    bit          ewen;
    bit [DW-1:0] e1;
    bit [DW-1:0] e2;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NREG); i++) model[i] = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_wen", 64'(rf_wen), 64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rdata1", 64'(rsp_rdata1), 64'(0));
    check("rst_rdata2", 64'(rsp_rdata2), 64'(0));
  endtask

  // Entered just after reset release in the low clock phase, cmd_valid=0.
  task automatic init_seq();
    for (int i = 1; i < int'(NREG); i++) begin
      #1;
      check("init_wen", 64'(rf_wen), 64'(1));
      check("init_waddr", 64'(rf_waddr), 64'(i));
      check("init_wdata", 64'(rf_wdata), 64'(0));
      check("init_done_low", 64'(init_done), 64'(0));
      check("init_ready_low", 64'(cmd_ready), 64'(0));
      check("init_rsp_low", 64'(rsp_valid), 64'(0));
      step();
    end
    #1;
    check("init_end_wen", 64'(rf_wen), 64'(0));
    check("init_end_done", 64'(init_done), 64'(1));
    check("init_end_ready", 64'(cmd_ready), 64'(1));
    check("init_end_rsp", 64'(rsp_valid), 64'(0));
    clear_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    check_reset_outputs();
    step();
    step();
    rst = 1'b1;
    init_seq();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_wen);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = a;
    cmd_addr2 = 5'($urandom_range(31, 0));
    cmd_wdata = d;
    #1;
    check("wr_ready", 64'(cmd_ready), 64'(1));
    check("wr_wen", 64'(rf_wen), 64'(exp_wen));
    if (exp_wen) begin
      check("wr_waddr", 64'(rf_waddr), 64'(a));
      check("wr_wdata", 64'(rf_wdata), 64'(d));
    end
    step();
    cmd_valid = 1'b0;
    if (a != '0) model[a] = d;
    #1;
    check("wr_no_rsp", 64'(rsp_valid), 64'(0));
  endtask

  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2, input int hold);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = a1;
    cmd_addr2 = a2;
    cmd_wdata = $urandom;
    #1;
    check("rd_raddr1", 64'(rf_raddr1), 64'(a1));
    check("rd_raddr2", 64'(rf_raddr2), 64'(a2));
    check("rd_wen", 64'(rf_wen), 64'(0));
    step();
    cmd_valid = 1'b0;
    cmd_addr = 5'($urandom_range(31, 0));
    cmd_addr2 = 5'($urandom_range(31, 0));
    #1;
    check("rd_rsp_valid", 64'(rsp_valid), 64'(1));
    check("rd_rdata1", 64'(rsp_rdata1), 64'(e1));
    check("rd_rdata2", 64'(rsp_rdata2), 64'(e2));
    check("rd_busy", 64'(cmd_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'($urandom_range(1, 0));
      step();
      cmd_addr = 5'($urandom_range(31, 0));
      #1;
      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_rdata1", 64'(rsp_rdata1), 64'(e1));
      check("hold_rdata2", 64'(rsp_rdata2), 64'(e2));
      check("hold_busy", 64'(cmd_ready), 64'(0));
      check("hold_wen", 64'(rf_wen), 64'(0));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    check("rsp_done_valid", 64'(rsp_valid), 64'(0));
    check("rsp_done_ready", 64'(cmd_ready), 64'(1));
  endtask

  function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
    return (a == '0) ? '0 : model[a];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_addr2 = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // wr, a1, a2, wdata, exp rf_wen, exp rdata1, exp rdata2
    vecs[0] = '{1'b1, 5'd7, 5'd0, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd7, 5'd0, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0, 5'd0, 32'h12345678, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 5'd3, 5'd0, 32'hA5A5A5A5, 1'b1, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 5'd3, 5'd7, 32'h0, 1'b0, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 5'd31, 5'd0, 32'h0BADF00D, 1'b1, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 5'd0, 5'd31, 32'h0, 1'b0, 32'h0, 32'h0BADF00D};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) do_write(vecs[i].a1, vecs[i].wd, vecs[i].ewen);
      else do_read(vecs[i].a1, vecs[i].a2, vecs[i].e1, vecs[i].e2, 0);
    end

    // Response held off for five cycles.
    do_read(5'd3, 5'd0, 32'hA5A5A5A5, 32'h0, 5);

    // Back-to-back writes, one per cycle, then read everything back.
    for (int i = 1; i < int'(NREG); i++) do_write(5'(i), 32'(i), 1'b1);
    for (int i = 1; i < int'(NREG); i++) begin
      do_read(5'(i), 5'(NREG - i), 32'(i), 32'(NREG - i), 0);
    end

    // Randomized traffic against the contents model.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      int kind;
      a1 = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
      a2 = 5'($urandom_range(31, 0));
      kind = int'($urandom_range(9, 0));
      if (kind < 4) begin
        do_write(a1, $urandom, a1 != '0);
      end else if (kind < 8) begin
        do_read(a1, a2, expect_rd(a1), expect_rd(a2), int'($urandom_range(3, 0)));
      end else begin
        cmd_valid = 1'b0;
        cmd_write = 1'b1;
        cmd_addr = 5'($urandom_range(31, 1));
        #1;
        check("idle_wen", 64'(rf_wen), 64'(0));
        check("idle_rsp", 64'(rsp_valid), 64'(0));
        step();
      end
    end

    // Reset while the clear counter sits at 10.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 1; i < 10; i++) step();
    #1;
    check("mid_init_cnt", 64'(rf_waddr), 64'(10));
    check("mid_init_wen", 64'(rf_wen), 64'(1));
    rst = 1'b0;
    #1;
    check_reset_outputs();
    step();
    rst = 1'b1;
    init_seq();

    // Reset with a response pending; it must not reappear.
    do_write(5'd9, 32'hCAFEF00D, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 5'd9;
    cmd_addr2 = 5'd9;
    step();
    cmd_valid = 1'b0;
    #1;
    check("resp_pre_rst_valid", 64'(rsp_valid), 64'(1));
    check("resp_pre_rst_data", 64'(rsp_rdata1), 64'(32'hCAFEF00D));
    rsp_ready = 1'b1;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    step();
    rsp_ready = 1'b0;
    rst = 1'b1;
    init_seq();
    do_read(5'd9, 5'd0, 32'h0, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
